mipi_csi2_pkt_tx: RTL and testbench

//  Byte-level MIPI CSI-2 packet transmitter; the transmit-side counterpart of the CSI-2 monitors.

---
 rtl/mipi_csi2_pkt_tx_if.sv | 27 ++
 rtl/mipi_csi2_pkt_tx.sv | 185 ++++++++++++++++++
 tb/tb_mipi_csi2_pkt_tx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_csi2_pkt_tx_if.sv
// Request, payload and framed-byte streams of the CSI-2 byte-level packet transmitter.
// master is the transmitter itself; slave is the source/sink environment around it.
interface mipi_csi2_pkt_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_dt;
    logic [1:0]  req_vc;
    logic [15:0] req_wc;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_sop;
    logic        tx_eop;

    modport master (
        input  req_valid, req_dt, req_vc, req_wc, pl_valid, pl_data, tx_ready,
        output req_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
    );

    modport slave (
        output req_valid, req_dt, req_vc, req_wc, pl_valid, pl_data, tx_ready,
        input  req_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
    );
endinterface

// File: rtl/mipi_csi2_pkt_tx.sv
// MIPI CSI-2 packet transmitter: frames a DT/VC/WC request and payload bytes into
// DI, WC, ECC, [payload, CRC16] on a registered byte stream with valid/ready flow control.
module mipi_csi2_pkt_tx #(
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] MAX_WC     = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    mipi_csi2_pkt_tx_if.master bus,
    output logic               busy,
    output logic               req_err,
    output logic [15:0]        pkt_cnt
);
    localparam int            GW       = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

    // Parity masks of the six ECC bits over the 24-bit header {WC, DI}.
    localparam logic [23:0] ECC_M0 = 24'hF12CB7;
    localparam logic [23:0] ECC_M1 = 24'hF2555B;
    localparam logic [23:0] ECC_M2 = 24'h749A6D;
    localparam logic [23:0] ECC_M3 = 24'hB8E38E;
    localparam logic [23:0] ECC_M4 = 24'hDF03F0;
    localparam logic [23:0] ECC_M5 = 24'hEFFC00;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CRC, S_GAP} state_t;

    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        return {2'b00, ^(d & ECC_M5), ^(d & ECC_M4), ^(d & ECC_M3),
                ^(d & ECC_M2), ^(d & ECC_M1), ^(d & ECC_M0)};
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? 16'h8408 : 16'h0000);
        end
        return c;
    endfunction

    state_t          state, state_d;
    logic [5:0]      hdr_dt;
    logic [1:0]      hdr_vc;
    logic [15:0]     hdr_wc;
    logic [1:0]      beat_idx;
    logic [15:0]     pay_left;
    logic [GW-1:0]   gap_cnt;
    logic [15:0]     crc;

    logic            slot_free, accept, req_long, req_bad, pl_take, hdr_short;
    logic            ld, ld_sop, ld_eop, pkt_end;
    logic [7:0]      ld_data;
    logic [7:0]      ecc;

    // The output slot can take a new byte when empty or when its byte leaves this cycle.
    assign slot_free     = !bus.tx_valid || bus.tx_ready;
    assign bus.req_ready = !rst && (state == S_IDLE) && slot_free;
    assign bus.pl_ready  = !rst && (state == S_PAY) && slot_free;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_long      = bus.req_dt > 6'h0F;
    assign req_bad       = req_long && (bus.req_wc > MAX_WC);
    assign pl_take       = bus.pl_valid && bus.pl_ready;
    assign hdr_short     = hdr_dt <= 6'h0F;
    assign ecc           = hdr_ecc({hdr_wc, hdr_vc, hdr_dt});
    assign busy          = state != S_IDLE;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        ld      = 1'b0;
        ld_data = 8'h00;
        ld_sop  = 1'b0;
        ld_eop  = 1'b0;
        pkt_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !req_bad) begin
                    ld      = 1'b1;
                    ld_data = {bus.req_vc, bus.req_dt};
                    ld_sop  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (slot_free) begin
                    ld = 1'b1;
                    case (beat_idx)
                        2'd1:    ld_data = hdr_wc[7:0];
                        2'd2:    ld_data = hdr_wc[15:8];
                        default: ld_data = ecc;
                    endcase
                    if (beat_idx == 2'd3) begin
                        if (hdr_short) begin
                            ld_eop  = 1'b1;
                            pkt_end = 1'b1;
                        end else if (hdr_wc == 16'd0) begin
                            state_d = S_CRC;
                        end else begin
                            state_d = S_PAY;
                        end
                    end
                end
            end
            S_PAY: begin
                if (pl_take) begin
                    ld      = 1'b1;
                    ld_data = bus.pl_data;
                    if (pay_left == 16'd1) state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (slot_free) begin
                    ld = 1'b1;
                    if (beat_idx == 2'd0) begin
                        ld_data = crc[7:0];
                    end else begin
                        ld_data = crc[15:8];
                        ld_eop  = 1'b1;
                        pkt_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                // Countdown only runs once the eop byte has left the slot.
                if (slot_free && gap_cnt <= GW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (pkt_end) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_dt       <= '0;
            hdr_vc       <= '0;
            hdr_wc       <= '0;
            beat_idx     <= '0;
            pay_left     <= '0;
            gap_cnt      <= '0;
            crc          <= 16'hFFFF;
            req_err      <= 1'b0;
            pkt_cnt      <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.tx_sop   <= 1'b0;
            bus.tx_eop   <= 1'b0;
        end else begin
            req_err <= accept && req_bad;

            if (accept) begin
                hdr_dt <= bus.req_dt;
                hdr_vc <= bus.req_vc;
                hdr_wc <= bus.req_wc;
            end

            // Beat index counts bytes within HDR (DI already sent on accept) and within CRC.
            if (accept)  beat_idx <= 2'd1;
            else if (ld) beat_idx <= (state_d != state) ? 2'd0 : beat_idx + 2'd1;

            if (accept)       pay_left <= bus.req_wc;
            else if (pl_take) pay_left <= pay_left - 16'd1;

            if (accept)       crc <= 16'hFFFF;
            else if (pl_take) crc <= crc16_byte(crc, bus.pl_data);

            if (pkt_end)                        gap_cnt <= GAP_INIT;
            else if (state == S_GAP && slot_free) gap_cnt <= gap_cnt - GW'(1);

            if (slot_free) begin
                bus.tx_valid <= ld;
                bus.tx_data  <= ld_data;
                bus.tx_sop   <= ld_sop;
                bus.tx_eop   <= ld_eop;
            end

            if (bus.tx_valid && bus.tx_ready && bus.tx_eop) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mipi_csi2_pkt_tx.sv
// Self-checking bench for mipi_csi2_pkt_tx: randomized requests/payload/backpressure
// compared beat by beat against a packet-level reference model.
module tb_mipi_csi2_pkt_tx;
    localparam int          GAP   = 2;
    localparam logic [15:0] MAXWC = 16'd64;

    // Syndrome column of each header bit: ECC is the XOR of the columns of all set bits.
    localparam logic [5:0] ECC_CODE [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, req_err;
    logic [15:0] pkt_cnt;

    mipi_csi2_pkt_tx_if bus();

    mipi_csi2_pkt_tx #(.GAP_CYCLES(GAP), .MAX_WC(MAXWC)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .req_err (req_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];
    logic [7:0] pl_q[$];
    int         gap_q[$];
    bit         rdy_rand = 1'b0;
    bit         pl_gaps = 1'b0;
    bit         pl_fire = 1'b0;
    bit         sop_held = 1'b0;
    int         beats = 0;
    int         pl_fires = 0;
    int         last_eop_cyc = -100;
    int         last_sop_cyc = 0;
    int         exp_pkts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] e;
        e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_CODE[i];
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] crc_model(input logic [7:0] bytes[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (bytes[k]) begin
            c ^= {8'h00, bytes[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // Backpressure source.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Payload source: presents the head of pl_q, optionally with random holes.
    initial begin
        bus.pl_valid = 1'b0;
        bus.pl_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (pl_fire && pl_q.size() > 0) void'(pl_q.pop_front());
            if (pl_q.size() > 0 && (!pl_gaps || $urandom_range(0, 2) != 0)) begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = pl_q[0];
            end else begin
                bus.pl_valid = 1'b0;
                bus.pl_data  = 8'($urandom);
            end
        end
    end

    // Output monitor: every handshaked beat is compared against the model stream.
    always @(negedge clk) begin
        logic [9:0] expb;
        if (rst) begin
            pl_fire  = 1'b0;
            sop_held = 1'b0;
        end else begin
            pl_fire = bus.pl_valid && bus.pl_ready;
            if (pl_fire) pl_fires++;
            if (bus.tx_valid && bus.tx_sop && !sop_held) begin
                gap_q.push_back(cyc - last_eop_cyc - 1);
                last_sop_cyc = cyc;
            end
            sop_held = bus.tx_valid && bus.tx_sop && !bus.tx_ready;
            if (bus.tx_valid && bus.tx_ready) begin
                beats++;
                if (exp_q.size() > 0) expb = exp_q.pop_front();
                else                  expb = 10'h3FF;
                check("tx_beat", {22'h0, bus.tx_data, bus.tx_sop, bus.tx_eop}, {22'h0, expb});
                if (bus.tx_eop) last_eop_cyc = cyc;
            end
        end
    end

    // Builds the expected packet, queues its payload, then presents the request until accepted.
    task automatic send_req(input string tag, input logic [5:0] dt, input logic [1:0] vc,
                            input logic [15:0] wc, input bit inc, output int acc_cyc);
        logic [7:0]  pay[$];
        logic [7:0]  di;
        logic [15:0] c;
        bit          is_long;
        bit          got;
        is_long = dt > 6'h0F;
        got     = 1'b0;
        acc_cyc = 0;
        di      = {vc, dt};
        if (!(is_long && wc > MAXWC)) begin
            exp_q.push_back({di, 2'b10});
            exp_q.push_back({wc[7:0], 2'b00});
            exp_q.push_back({wc[15:8], 2'b00});
            exp_q.push_back({ecc_model({wc, di}), 1'b0, !is_long});
            if (is_long) begin
                for (int k = 0; k < int'(wc); k++) pay.push_back(inc ? 8'(k) : 8'($urandom));
                foreach (pay[k]) begin
                    exp_q.push_back({pay[k], 2'b00});
                    pl_q.push_back(pay[k]);
                end
                c = crc_model(pay);
                exp_q.push_back({c[7:0], 2'b00});
                exp_q.push_back({c[15:8], 2'b01});
            end
            exp_pkts++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_dt    = dt;
        bus.req_vc    = vc;
        bus.req_wc    = wc;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        check({"accept_", tag}, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_dt    = 6'($urandom);
        bus.req_vc    = 2'($urandom);
        bus.req_wc    = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
        check({"idle_", tag}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int fires0;
        bit any_valid;
        bus.req_valid = 1'b0;
        bus.req_dt    = '0;
        bus.req_vc    = '0;
        bus.req_wc    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_sop_eop", {30'h0, bus.tx_sop, bus.tx_eop}, 32'd0);
        check("rst_busy_err", {30'h0, busy, req_err}, 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_readies", {30'h0, bus.req_ready, bus.pl_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // 1: short packet, all zero
        beats = 0;
        send_req("t1", 6'h00, 2'd0, 16'h0000, 1'b0, acc);
        wait_done("t1");
        check("t1_beats", 32'(beats), 32'd4);
        check("t1_sop_latency", 32'(last_sop_cyc - acc), 32'd1);
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

        // 2: long packet with WC=0
        beats = 0;
        send_req("t2", 6'h2A, 2'd1, 16'h0000, 1'b0, acc);
        wait_done("t2");
        check("t2_beats", 32'(beats), 32'd6);

        // 3: RAW8 with payload holes and random backpressure; one surplus byte must stay queued
        beats    = 0;
        fires0   = pl_fires;
        rdy_rand = 1'b1;
        pl_gaps  = 1'b1;
        send_req("t3", 6'h2A, 2'($urandom), 16'd16, 1'b1, acc);
        pl_q.push_back(8'hA5);
        wait_done("t3");
        repeat (5) @(negedge clk);
        check("t3_beats", 32'(beats), 32'd22);
        check("t3_pl_taken", 32'(pl_fires - fires0), 32'd16);
        check("t3_extra_left", 32'(pl_q.size()), 32'd1);
        if (pl_q.size() > 0) check("t3_extra_byte", 32'(pl_q[0]), 32'hA5);
        pl_q.delete();
        rdy_rand = 1'b0;
        pl_gaps  = 1'b0;

        // 4: three back-to-back requests, exact inter-packet gap
        gap_q.delete();
        send_req("t4a", 6'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), 1'b0, acc);
        send_req("t4b", 6'($urandom_range(16, 63)), 2'($urandom), 16'd5, 1'b0, acc);
        send_req("t4c", 6'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), 1'b0, acc);
        wait_done("t4");
        check("t4_sop_count", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("t4_gap_ab", 32'(gap_q[1]), 32'(GAP));
            check("t4_gap_bc", 32'(gap_q[2]), 32'(GAP));
        end
        check("t4_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

        // 5: oversize request is consumed and flagged, then MAX_WC itself goes through
        beats = 0;
        send_req("t5_bad", 6'h2A, 2'd0, MAXWC + 16'd1, 1'b0, acc);
        @(negedge clk);
        check("t5_req_err_hi", 32'(req_err), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        any_valid = bus.tx_valid;
        @(negedge clk);
        check("t5_req_err_lo", 32'(req_err), 32'd0);
        repeat (4) begin
            any_valid |= bus.tx_valid;
            @(negedge clk);
        end
        check("t5_no_tx", 32'(any_valid), 32'd0);
        rdy_rand = 1'b1;
        send_req("t5_max", 6'h2A, 2'd2, MAXWC, 1'b0, acc);
        wait_done("t5");
        check("t5_beats", 32'(beats), 32'(int'(MAXWC) + 6));
        check("t5_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        rdy_rand = 1'b0;

        // 6: reset after five payload bytes, then a clean packet with a fresh CRC
        fires0 = pl_fires;
        send_req("t6_cut", 6'h2B, 2'd3, 16'd16, 1'b0, acc);
        for (int t = 0; t < 400; t++) begin
            if (pl_fires - fires0 >= 5) break;
            @(negedge clk);
        end
        check("t6_reached_byte5", 32'(pl_fires - fires0), 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("t6_sop_eop_data", {22'h0, bus.tx_data, bus.tx_sop, bus.tx_eop}, 32'd0);
        check("t6_busy_err", {30'h0, busy, req_err}, 32'd0);
        check("t6_pkt_cnt", 32'(pkt_cnt), 32'd0);
        exp_q.delete();
        pl_q.delete();
        exp_pkts = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        beats = 0;
        send_req("t6_next", 6'h2A, 2'd0, 16'd16, 1'b0, acc);
        wait_done("t6");
        check("t6_beats", 32'(beats), 32'd22);
        check("t6_pkt_cnt_after", 32'(pkt_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
